// File: rtl/swb_pkg.sv
// Shared types and width helpers for the multi-channel sliding window buffer.
package swb_pkg;

  typedef enum logic {SWB_IDLE, SWB_ACTIVE} swb_state_e;
  typedef enum logic {SWB_ZERO, SWB_REPL} swb_border_e;

  // Address width for a counter that indexes 0..depth-1.
  function automatic int swb_addr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Width of a configuration field that must hold 1..max_val inclusive.
  function automatic int swb_cfg_w(input int max_val);
    return $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/swb_line_ram.sv
// One line of pixel storage: single write port, asynchronous read, no reset.
module swb_line_ram
  import swb_pkg::*;
#(
  parameter int DEPTH  = 64,
  parameter int DATA_W = 24
) (
  input  logic                         clk,
  input  logic                         wr_en,
  input  logic [swb_addr_w(DEPTH)-1:0] addr,
  input  logic [DATA_W-1:0]            wr_data,
  output logic [DATA_W-1:0]            rd_data
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[addr] <= wr_data;
  end

  assign rd_data = mem_q[addr];

endmodule

// File: rtl/sliding_window_buffer_mc.sv
// Streams raster pixels and emits one bottom-right aligned WINDOWxWINDOW window
// per accepted pixel, with runtime frame size, border mode and backpressure.
module sliding_window_buffer_mc
  import swb_pkg::*;
#(
  parameter int MAX_WIDTH   = 64,
  parameter int MAX_HEIGHT  = 64,
  parameter int PIXEL_WIDTH = 8,
  parameter int CHANNELS    = 3,
  parameter int WINDOW      = 3
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic [swb_cfg_w(MAX_WIDTH)-1:0]               cfg_width,
  input  logic [swb_cfg_w(MAX_HEIGHT)-1:0]              cfg_height,
  input  logic                                          cfg_border,
  input  logic                                          in_valid,
  output logic                                          in_ready,
  input  logic [CHANNELS*PIXEL_WIDTH-1:0]               in_pixel,
  output logic                                          win_valid,
  input  logic                                          win_ready,
  output logic [WINDOW*WINDOW*CHANNELS*PIXEL_WIDTH-1:0] win_data,
  output logic                                          win_sof,
  output logic                                          win_eof
);

  localparam int PX_W  = CHANNELS * PIXEL_WIDTH;
  localparam int COL_W = swb_addr_w(MAX_WIDTH);
  localparam int ROW_W = swb_addr_w(MAX_HEIGHT);
  localparam int CW_W  = swb_cfg_w(MAX_WIDTH);
  localparam int CH_W  = swb_cfg_w(MAX_HEIGHT);

  swb_state_e                         state_q, state_d;
  swb_border_e                        border_q, border_d, eff_border;
  logic [COL_W-1:0]                   col_q, col_d;
  logic [ROW_W-1:0]                   row_q, row_d;
  logic [CW_W-1:0]                    width_q, width_d, eff_width;
  logic [CH_W-1:0]                    height_q, height_d, eff_height;
  logic                               win_valid_q, win_valid_d;
  logic                               sof_q, sof_d, eof_q, eof_d;
  logic [WINDOW-1:0][WINDOW-1:0][PX_W-1:0] win_q, win_d;

  logic                               accept, col_last, row_last;
  logic [WINDOW-2:0][PX_W-1:0]        line_rd;
  logic [WINDOW-1:0][PX_W-1:0]        col_raw, col_b;
  logic [PX_W-1:0]                    edge_px;

  assign in_ready  = !win_valid_q || win_ready;
  assign accept    = in_valid && in_ready;
  assign win_valid = win_valid_q;
  assign win_data  = win_q;
  assign win_sof   = sof_q;
  assign win_eof   = eof_q;

  // The first pixel of a frame must already see the new configuration.
  assign eff_width  = (state_q == SWB_IDLE) ? cfg_width : width_q;
  assign eff_height = (state_q == SWB_IDLE) ? cfg_height : height_q;
  assign eff_border = (state_q == SWB_IDLE) ? (cfg_border ? SWB_REPL : SWB_ZERO) : border_q;

  assign col_last = (CW_W'(col_q) == eff_width - CW_W'(1));
  assign row_last = (CH_W'(row_q) == eff_height - CH_W'(1));

  for (genvar j = 0; j < WINDOW - 1; j++) begin : g_line
    logic [PX_W-1:0] wr_data;
    if (j == WINDOW - 2) begin : g_bottom
      assign wr_data = in_pixel;
    end else begin : g_upper
      assign wr_data = line_rd[j+1];
    end
    swb_line_ram #(.DEPTH(MAX_WIDTH), .DATA_W(PX_W)) u_line (
      .clk     (clk),
      .wr_en   (accept),
      .addr    (col_q),
      .wr_data (wr_data),
      .rd_data (line_rd[j])
    );
  end

  assign col_raw = {in_pixel, line_rd};

  // Rows above the frame come from stale line RAM; mask or clamp to row 0.
  always_comb begin
    edge_px = col_raw[WINDOW-1];
    col_b   = col_raw;
    for (int wr = WINDOW - 2; wr >= 0; wr--) begin
      if (int'(row_q) + wr >= WINDOW - 1) edge_px = col_raw[wr];
      else col_b[wr] = (eff_border == SWB_REPL) ? edge_px : '0;
    end
  end

  always_comb begin
    win_d = win_q;
    if (accept) begin
      for (int wr = 0; wr < WINDOW; wr++) begin
        win_d[wr][WINDOW-1] = col_b[wr];
        for (int wc = 0; wc < WINDOW - 1; wc++) begin
          if (col_q == '0) win_d[wr][wc] = (eff_border == SWB_REPL) ? col_b[wr] : '0;
          else win_d[wr][wc] = win_q[wr][wc+1];
        end
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    border_d    = border_q;
    width_d     = width_q;
    height_d    = height_q;
    col_d       = col_q;
    row_d       = row_q;
    sof_d       = sof_q;
    eof_d       = eof_q;
    win_valid_d = win_valid_q && !win_ready;
    if (accept) begin
      win_valid_d = 1'b1;
      sof_d       = (row_q == '0) && (col_q == '0);
      eof_d       = row_last && col_last;
      if (state_q == SWB_IDLE) begin
        state_d  = SWB_ACTIVE;
        width_d  = cfg_width;
        height_d = cfg_height;
        border_d = eff_border;
      end
      if (col_last) begin
        col_d = '0;
        if (row_last) begin
          row_d   = '0;
          state_d = SWB_IDLE;
        end else begin
          row_d = row_q + ROW_W'(1);
        end
      end else begin
        col_d = col_q + COL_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= SWB_IDLE;
      border_q    <= SWB_ZERO;
      width_q     <= '0;
      height_q    <= '0;
      col_q       <= '0;
      row_q       <= '0;
      sof_q       <= 1'b0;
      eof_q       <= 1'b0;
      win_valid_q <= 1'b0;
      win_q       <= '0;
    end else begin
      state_q     <= state_d;
      border_q    <= border_d;
      width_q     <= width_d;
      height_q    <= height_d;
      col_q       <= col_d;
      row_q       <= row_d;
      sof_q       <= sof_d;
      eof_q       <= eof_d;
      win_valid_q <= win_valid_d;
      win_q       <= win_d;
    end
  end

endmodule

// File: tb/tb_sliding_window_buffer_mc.sv
// Directed bench for sliding_window_buffer_mc: frame streams checked against a
// causal window model plus hand-computed windows, sizes, markers and stalls.
module tb_sliding_window_buffer_mc;
  localparam int MW  = 64;
  localparam int MH  = 64;
  localparam int PW  = 8;
  localparam int CH  = 3;
  localparam int W   = 3;
  localparam int PXW = PW * CH;
  localparam int WD  = W * W * PXW;

  logic           clk = 1'b0;
  logic           rst;
  logic [6:0]     cfg_width, cfg_height;
  logic           cfg_border;
  logic           in_valid, in_ready;
  logic [PXW-1:0] in_pixel;
  logic           win_valid, win_ready, win_sof, win_eof;
  logic [WD-1:0]  win_data;

  int checks = 0;
  int errors = 0;

  logic [PXW-1:0] frame [MW*MH];
  int             m_r, m_c, m_w, m_h;
  logic           m_b, m_active;
  logic           exp_valid, exp_sof, exp_eof;
  logic [WD-1:0]  exp_data;
  int             win_cnt, sof_at, eof_at;

  sliding_window_buffer_mc #(
    .MAX_WIDTH(MW), .MAX_HEIGHT(MH), .PIXEL_WIDTH(PW), .CHANNELS(CH), .WINDOW(W)
  ) dut (
    .clk(clk), .rst(rst), .cfg_width(cfg_width), .cfg_height(cfg_height),
    .cfg_border(cfg_border), .in_valid(in_valid), .in_ready(in_ready),
    .in_pixel(in_pixel), .win_valid(win_valid), .win_ready(win_ready),
    .win_data(win_data), .win_sof(win_sof), .win_eof(win_eof)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [WD-1:0] obs, input logic [WD-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [PXW-1:0] ramp(input int idx);
    logic [7:0] v;
    v = idx[7:0];
    return {8'h00, 8'hA0 + v, v};
  endfunction

  function automatic logic [PXW-1:0] rnd_px();
    logic [31:0] r;
    r = $urandom();
    return r[PXW-1:0];
  endfunction

  function automatic logic [PXW-1:0] ref_px(input int r, input int c);
    int rr, cc;
    rr = r;
    cc = c;
    if (rr < 0 || cc < 0) begin
      if (!m_b) return '0;
      if (rr < 0) rr = 0;
      if (cc < 0) cc = 0;
    end
    return frame[rr*m_w+cc];
  endfunction

  // Hand check of one element: ramp value v in channel 0, A0+v in channel 1.
  task automatic hand_px(input string tag, input int wr, input int wc, input int v);
    logic [7:0] v8;
    v8 = v[7:0];
    chk(tag, win_data[(wr*W+wc)*PXW +: PXW], {8'h00, 8'hA0 + v8, v8});
  endtask

  task automatic hand_row(input string tag, input int wr, input int a, input int b, input int c);
    hand_px(tag, wr, 0, a);
    hand_px(tag, wr, 1, b);
    hand_px(tag, wr, 2, c);
  endtask

  // One cycle from a negedge to the next: drive, check in_ready, then check outputs.
  task automatic tick(input logic v, input logic [PXW-1:0] px, input logic rdy, output logic acc);
    in_valid  = v;
    in_pixel  = px;
    win_ready = rdy;
    #1;
    chk("in_ready", in_ready, !exp_valid || rdy);
    acc = v && (!exp_valid || rdy);
    if (acc) begin
      if (!m_active) begin
        m_w = int'(cfg_width);
        m_h = int'(cfg_height);
        m_b = cfg_border;
        m_active = 1'b1;
      end
      frame[m_r*m_w+m_c] = px;
      for (int wr = 0; wr < W; wr++)
        for (int wc = 0; wc < W; wc++)
          exp_data[(wr*W+wc)*PXW +: PXW] = ref_px(m_r + wr - (W-1), m_c + wc - (W-1));
      exp_sof = (m_r == 0) && (m_c == 0);
      exp_eof = (m_r == m_h - 1) && (m_c == m_w - 1);
      if (m_c == m_w - 1) begin
        m_c = 0;
        if (m_r == m_h - 1) begin
          m_r = 0;
          m_active = 1'b0;
        end else m_r++;
      end else m_c++;
      exp_valid = 1'b1;
    end else if (rdy) begin
      exp_valid = 1'b0;
    end
    @(negedge clk);
    chk("win_valid", win_valid, exp_valid);
    if (exp_valid) begin
      chk("win_data", win_data, exp_data);
      chk("win_sof", win_sof, exp_sof);
      chk("win_eof", win_eof, exp_eof);
    end
    if (acc) begin
      win_cnt++;
      if (win_sof) sof_at = win_cnt;
      if (win_eof) eof_at = win_cnt;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    win_ready = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    m_active = 1'b0;
    m_r = 0;
    m_c = 0;
    exp_valid = 1'b0;
    #1;
    chk("rst_valid", win_valid, 1'b0);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_data", win_data, '0);
    chk("rst_sof", win_sof, 1'b0);
    chk("rst_eof", win_eof, 1'b0);
  endtask

  initial begin
    logic acc;
    logic [WD-1:0] held;
    int idx, cyc;

    rst = 1'b1; in_valid = 1'b0; in_pixel = '0; win_ready = 1'b1;
    cfg_width = 7'd4; cfg_height = 7'd4; cfg_border = 1'b0;
    m_r = 0; m_c = 0; m_w = 4; m_h = 4; m_b = 1'b0; m_active = 1'b0;
    exp_valid = 1'b0; exp_sof = 1'b0; exp_eof = 1'b0; exp_data = '0;
    win_cnt = 0; sof_at = 0; eof_at = 0;
    @(negedge clk);
    @(negedge clk);
    do_reset();

    // T1: 4x4 ramp, zero border, no stalls
    cfg_width = 7'd4; cfg_height = 7'd4; cfg_border = 1'b0; win_cnt = 0;
    for (int i = 0; i < 16; i++) begin
      tick(1'b1, ramp(i), 1'b1, acc);
      if (i == 0) chk("t1_win00", win_data, {24'h00A000, 192'h0});
      if (i == 10) begin
        hand_row("t1_win22_r0", 0, 0, 1, 2);
        hand_row("t1_win22_r1", 1, 4, 5, 6);
        hand_row("t1_win22_r2", 2, 8, 9, 10);
      end
    end
    chk("t1_count", win_cnt, 16);
    chk("t1_sof_at", sof_at, 1);
    chk("t1_eof_at", eof_at, 16);

    // T2: same frame, replicate border
    cfg_border = 1'b1; win_cnt = 0;
    for (int i = 0; i < 16; i++) begin
      tick(1'b1, ramp(i), 1'b1, acc);
      if (i == 1) begin
        hand_row("t2_win01_r0", 0, 0, 0, 1);
        hand_row("t2_win01_r1", 1, 0, 0, 1);
        hand_row("t2_win01_r2", 2, 0, 0, 1);
      end
      if (i == 5) begin
        hand_row("t2_win11_r0", 0, 0, 0, 1);
        hand_row("t2_win11_r1", 1, 0, 0, 1);
        hand_row("t2_win11_r2", 2, 4, 4, 5);
      end
    end
    chk("t2_eof_at", eof_at, 16);

    // T3: backpressure on cycles 3..7 with in_valid held
    cfg_border = 1'b0; win_cnt = 0; idx = 0; cyc = 0; held = '0;
    while (idx < 16 && cyc < 60) begin
      tick(1'b1, ramp(idx), !(cyc >= 3 && cyc <= 7), acc);
      if (acc) idx++;
      if (cyc >= 3 && cyc <= 7) chk("t3_stall_in_ready", in_ready, 1'b0);
      if (cyc == 3) held = win_data;
      if (cyc == 7) chk("t3_held_data", win_data, held);
      cyc++;
    end
    chk("t3_accepts", idx, 16);
    chk("t3_cycles", cyc, 21);
    chk("t3_eof_at", eof_at, 16);

    // T4: 8x2 zero then 3x5 replicate, random pixels, cfg changed mid-frame
    cfg_width = 7'd8; cfg_height = 7'd2; cfg_border = 1'b0; win_cnt = 0;
    for (int i = 0; i < 16; i++) begin
      tick(1'b1, rnd_px(), 1'b1, acc);
      if (i == 4) begin
        cfg_width = 7'd5; cfg_height = 7'd7; cfg_border = 1'b1;
      end
    end
    chk("t4_f1_sof_at", sof_at, 1);
    chk("t4_f1_eof_at", eof_at, 16);
    cfg_width = 7'd3; cfg_height = 7'd5; cfg_border = 1'b1;
    for (int i = 0; i < 15; i++) begin
      tick(1'b1, rnd_px(), 1'b1, acc);
      if (i == 6) begin
        cfg_width = 7'd8; cfg_height = 7'd2; cfg_border = 1'b0;
      end
    end
    chk("t4_f2_sof_at", sof_at, 17);
    chk("t4_f2_eof_at", eof_at, 31);

    // T5: reset after 6 accepts, next pixel restarts at (0,0)
    cfg_width = 7'd4; cfg_height = 7'd4; cfg_border = 1'b0;
    for (int i = 0; i < 6; i++) tick(1'b1, ramp(i), 1'b1, acc);
    do_reset();
    tick(1'b1, ramp(99), 1'b1, acc);
    chk("t5_sof", win_sof, 1'b1);
    chk("t5_border", win_data[WD-PXW-1:0], '0);
    chk("t5_pixel", win_data[WD-1 -: PXW], ramp(99));
    do_reset();

    // T6: width 1, height 3; then a 1x1 frame
    cfg_width = 7'd1; cfg_height = 7'd3; cfg_border = 1'b0; win_cnt = 0;
    for (int i = 0; i < 3; i++) begin
      tick(1'b1, rnd_px(), 1'b1, acc);
      for (int wr = 0; wr < W; wr++)
        chk("t6_left_cols", win_data[wr*W*PXW +: 2*PXW], '0);
      if (i == 0) begin
        chk("t6_w1_sof", win_sof, 1'b1);
        chk("t6_w1_eof", win_eof, 1'b0);
      end
    end
    chk("t6_w3_eof", win_eof, 1'b1);
    chk("t6_eof_at", eof_at, 3);
    cfg_width = 7'd1; cfg_height = 7'd1; cfg_border = 1'b1;
    tick(1'b1, rnd_px(), 1'b1, acc);
    chk("t6_1x1_sof", win_sof, 1'b1);
    chk("t6_1x1_eof", win_eof, 1'b1);
    tick(1'b0, '0, 1'b1, acc);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
